alu_rs_multi_entry: RTL and testbench

Parametrised multi-entry ALU reservation station. Successor to the single-entry station: holds NUM_ENTRIES pending ALU operations, each with its own opcode and destination tag. Each entry snoops the CDB for missing operands and arbitrates ready entries onto one CDB producer port. Sits between the dispatch/rename stage and the CDB arbiter.

---
 rtl/alu_rs_pkg.sv | 36 +++
 rtl/alu_rs_entry.sv | 128 ++++++++++++
 rtl/alu_rs_multi_entry.sv | 129 ++++++++++++
 tb/tb_alu_rs_multi_entry.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// ---------------------------------------------------------------------------
// alu_rs_pkg : opcodes and shared ALU function for the ALU reservation stations
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_rs_pkg;

  localparam int ALU_OP_WIDTH  = 2;
  localparam int ALU_MAX_WIDTH = 64;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 2'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 2'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 2'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 2'd3;

  // Operands are zero-extended by the caller; the caller truncates the result.
  function automatic logic [ALU_MAX_WIDTH-1:0] alu_compute(
    input logic [ALU_OP_WIDTH-1:0]  op,
    input logic [ALU_MAX_WIDTH-1:0] a,
    input logic [ALU_MAX_WIDTH-1:0] b
  );
    logic [ALU_MAX_WIDTH-1:0] r;
    case (op)
      ALU_OP_ADD: r = a + b;
      ALU_OP_SUB: r = a - b;
      ALU_OP_AND: r = a & b;
      ALU_OP_XOR: r = a ^ b;
      default:    r = a + b;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rs_entry.sv
// ---------------------------------------------------------------------------
// alu_rs_entry : one reservation-station entry with CDB snoop and dispatch bypass
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_rs_entry
  import alu_rs_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CDB_TAG_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc,
  input  logic [ALU_OP_WIDTH-1:0]  op,
  input  logic [CDB_TAG_WIDTH-1:0] dest_tag,
  input  logic [DATA_WIDTH-1:0]    a_data,
  input  logic                     a_valid,
  input  logic [DATA_WIDTH-1:0]    b_data,
  input  logic                     b_valid,
  input  logic                     cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_in_data,
  input  logic                     free_en,
  output logic                     busy,
  output logic                     ready,
  output logic [CDB_TAG_WIDTH-1:0] tag,
  output logic [DATA_WIDTH-1:0]    result
);

  logic                     busy_q,  busy_d;
  logic [ALU_OP_WIDTH-1:0]  op_q,    op_d;
  logic [CDB_TAG_WIDTH-1:0] dest_q,  dest_d;
  logic [DATA_WIDTH-1:0]    a_val_q, a_val_d, b_val_q, b_val_d;
  logic                     a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [CDB_TAG_WIDTH-1:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic [ALU_MAX_WIDTH-1:0] a_ext, b_ext;

  always_comb begin
    busy_d  = busy_q;
    op_d    = op_q;
    dest_d  = dest_q;
    a_val_d = a_val_q;
    a_vld_d = a_vld_q;
    a_tag_d = a_tag_q;
    b_val_d = b_val_q;
    b_vld_d = b_vld_q;
    b_tag_d = b_tag_q;
    if (alloc) begin
      busy_d  = 1'b1;
      op_d    = op;
      dest_d  = dest_tag;
      a_tag_d = a_data[CDB_TAG_WIDTH-1:0];
      b_tag_d = b_data[CDB_TAG_WIDTH-1:0];
      // A producer broadcasting in the dispatch cycle is caught here, not lost.
      if (a_valid) begin
        a_vld_d = 1'b1;
        a_val_d = a_data;
      end else if (cdb_in_valid && cdb_in_tag == a_data[CDB_TAG_WIDTH-1:0]) begin
        a_vld_d = 1'b1;
        a_val_d = cdb_in_data;
      end else begin
        a_vld_d = 1'b0;
        a_val_d = '0;
      end
      if (b_valid) begin
        b_vld_d = 1'b1;
        b_val_d = b_data;
      end else if (cdb_in_valid && cdb_in_tag == b_data[CDB_TAG_WIDTH-1:0]) begin
        b_vld_d = 1'b1;
        b_val_d = cdb_in_data;
      end else begin
        b_vld_d = 1'b0;
        b_val_d = '0;
      end
    end else begin
      if (free_en) busy_d = 1'b0;
      if (busy_q && !a_vld_q && cdb_in_valid && cdb_in_tag == a_tag_q) begin
        a_vld_d = 1'b1;
        a_val_d = cdb_in_data;
      end
      if (busy_q && !b_vld_q && cdb_in_valid && cdb_in_tag == b_tag_q) begin
        b_vld_d = 1'b1;
        b_val_d = cdb_in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      op_q    <= '0;
      dest_q  <= '0;
      a_val_q <= '0;
      a_vld_q <= 1'b0;
      a_tag_q <= '0;
      b_val_q <= '0;
      b_vld_q <= 1'b0;
      b_tag_q <= '0;
    end else begin
      busy_q  <= busy_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      a_val_q <= a_val_d;
      a_vld_q <= a_vld_d;
      a_tag_q <= a_tag_d;
      b_val_q <= b_val_d;
      b_vld_q <= b_vld_d;
      b_tag_q <= b_tag_d;
    end
  end

  always_comb begin
    a_ext                 = '0;
    a_ext[DATA_WIDTH-1:0] = a_val_q;
    b_ext                 = '0;
    b_ext[DATA_WIDTH-1:0] = b_val_q;
  end

  assign busy   = busy_q;
  assign ready  = busy_q && a_vld_q && b_vld_q;
  assign tag    = dest_q;
  assign result = DATA_WIDTH'(alu_compute(op_q, a_ext, b_ext));

endmodule

`default_nettype wire

// File: rtl/alu_rs_multi_entry.sv
// ---------------------------------------------------------------------------
// alu_rs_multi_entry : NUM_ENTRIES-deep ALU reservation station, one CDB port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_rs_multi_entry
  import alu_rs_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CDB_TAG_WIDTH = 4,
  parameter int NUM_ENTRIES   = 4,
  parameter int IDX_WIDTH     = $clog2(NUM_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_in_data,
  input  logic                     dispatch_en,
  input  logic [ALU_OP_WIDTH-1:0]  dispatch_op,
  input  logic [CDB_TAG_WIDTH-1:0] dispatch_dest_tag,
  input  logic [DATA_WIDTH-1:0]    dispatch_a_data,
  input  logic                     dispatch_a_valid,
  input  logic [DATA_WIDTH-1:0]    dispatch_b_data,
  input  logic                     dispatch_b_valid,
  output logic                     dispatch_ready,
  output logic                     cdb_out_request,
  output logic [CDB_TAG_WIDTH-1:0] cdb_out_tag,
  output logic [DATA_WIDTH-1:0]    cdb_out_data,
  input  logic                     cdb_out_accepted,
  output logic [IDX_WIDTH:0]       occupancy
);

  logic [NUM_ENTRIES-1:0]   busy, ready, alloc, free_en;
  logic [CDB_TAG_WIDTH-1:0] ent_tag    [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]    ent_result [NUM_ENTRIES];

  logic                 free_found, ready_any, accept;
  logic [IDX_WIDTH-1:0] free_idx, ready_idx, offer_idx;
  logic                 lock_valid_q, lock_valid_d;
  logic [IDX_WIDTH-1:0] lock_idx_q,   lock_idx_d;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    alu_rs_entry #(
      .DATA_WIDTH   (DATA_WIDTH),
      .CDB_TAG_WIDTH(CDB_TAG_WIDTH)
    ) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (alloc[gi]),
      .op          (dispatch_op),
      .dest_tag    (dispatch_dest_tag),
      .a_data      (dispatch_a_data),
      .a_valid     (dispatch_a_valid),
      .b_data      (dispatch_b_data),
      .b_valid     (dispatch_b_valid),
      .cdb_in_valid(cdb_in_valid),
      .cdb_in_tag  (cdb_in_tag),
      .cdb_in_data (cdb_in_data),
      .free_en     (free_en[gi]),
      .busy        (busy[gi]),
      .ready       (ready[gi]),
      .tag         (ent_tag[gi]),
      .result      (ent_result[gi])
    );
  end

  // Both encoders scan high-to-low so the lowest index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    ready_any  = 1'b0;
    ready_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(i);
      end
      if (ready[i]) begin
        ready_any = 1'b1;
        ready_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign dispatch_ready  = free_found;
  assign cdb_out_request = lock_valid_q || ready_any;
  assign offer_idx       = lock_valid_q ? lock_idx_q : ready_idx;
  assign accept          = cdb_out_request && cdb_out_accepted;
  assign cdb_out_tag     = cdb_out_request ? ent_tag[offer_idx]    : '0;
  assign cdb_out_data    = cdb_out_request ? ent_result[offer_idx] : '0;

  always_comb begin
    alloc     = '0;
    free_en   = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      alloc[i]   = dispatch_en && free_found && (free_idx == IDX_WIDTH'(i));
      free_en[i] = accept && (offer_idx == IDX_WIDTH'(i));
      occupancy  = occupancy + (IDX_WIDTH + 1)'(busy[i]);
    end
  end

  // The first unaccepted offer pins the output until the arbiter takes it.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    if (accept) begin
      lock_valid_d = 1'b0;
    end else if (cdb_out_request && !lock_valid_q) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = ready_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs_multi_entry.sv
// ---------------------------------------------------------------------------
// tb_alu_rs_multi_entry : directed bench with a behavioural station model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_rs_multi_entry;

  localparam int NE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cdb_in_valid = 1'b0;
  logic [3:0] cdb_in_tag = '0;
  logic [7:0] cdb_in_data = '0;
  logic       dispatch_en = 1'b0;
  logic [1:0] dispatch_op = '0;
  logic [3:0] dispatch_dest_tag = '0;
  logic [7:0] dispatch_a_data = '0;
  logic       dispatch_a_valid = 1'b0;
  logic [7:0] dispatch_b_data = '0;
  logic       dispatch_b_valid = 1'b0;
  logic       cdb_out_accepted = 1'b0;
  logic       dispatch_ready, cdb_out_request;
  logic [3:0] cdb_out_tag;
  logic [7:0] cdb_out_data;
  logic [2:0] occupancy;

  int checks = 0;
  int errors = 0;

  alu_rs_multi_entry #(.DATA_WIDTH(8), .CDB_TAG_WIDTH(4), .NUM_ENTRIES(NE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cdb_in_valid     (cdb_in_valid),
    .cdb_in_tag       (cdb_in_tag),
    .cdb_in_data      (cdb_in_data),
    .dispatch_en      (dispatch_en),
    .dispatch_op      (dispatch_op),
    .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_a_data  (dispatch_a_data),
    .dispatch_a_valid (dispatch_a_valid),
    .dispatch_b_data  (dispatch_b_data),
    .dispatch_b_valid (dispatch_b_valid),
    .dispatch_ready   (dispatch_ready),
    .cdb_out_request  (cdb_out_request),
    .cdb_out_tag      (cdb_out_tag),
    .cdb_out_data     (cdb_out_data),
    .cdb_out_accepted (cdb_out_accepted),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_busy [NE];
  bit [1:0] m_op   [NE];
  bit [3:0] m_dest [NE];
  bit [7:0] m_a    [NE];
  bit [7:0] m_b    [NE];
  bit       m_av   [NE];
  bit       m_bv   [NE];
  bit [3:0] m_at   [NE];
  bit [3:0] m_bt   [NE];
  bit       m_lock = 1'b0;
  int       m_lidx = 0;

  function automatic bit [7:0] model_alu(input bit [1:0] op, input bit [7:0] a, input bit [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Entry currently on offer, or -1 if none.
  function automatic int model_offer();
    if (m_lock) return m_lidx;
    for (int i = 0; i < NE; i++)
      if (m_busy[i] && m_av[i] && m_bv[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int  off;
    int  fs;
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) m_busy[i] <= 1'b0;
      m_lock <= 1'b0;
      m_lidx <= 0;
    end else begin
      off = model_offer();
      fs = -1;
      for (int i = NE - 1; i >= 0; i--) if (!m_busy[i]) fs = i;
      for (int i = 0; i < NE; i++) begin
        if (m_busy[i] && !m_av[i] && cdb_in_valid && cdb_in_tag == m_at[i]) begin
          m_av[i] <= 1'b1;
          m_a[i]  <= cdb_in_data;
        end
        if (m_busy[i] && !m_bv[i] && cdb_in_valid && cdb_in_tag == m_bt[i]) begin
          m_bv[i] <= 1'b1;
          m_b[i]  <= cdb_in_data;
        end
      end
      if (off >= 0 && cdb_out_accepted) begin
        m_busy[off] <= 1'b0;
        m_lock      <= 1'b0;
      end else if (off >= 0 && !m_lock) begin
        m_lock <= 1'b1;
        m_lidx <= off;
      end
      if (dispatch_en && fs >= 0) begin
        m_busy[fs] <= 1'b1;
        m_op[fs]   <= dispatch_op;
        m_dest[fs] <= dispatch_dest_tag;
        m_at[fs]   <= dispatch_a_data[3:0];
        m_bt[fs]   <= dispatch_b_data[3:0];
        if (dispatch_a_valid) begin
          m_av[fs] <= 1'b1; m_a[fs] <= dispatch_a_data;
        end else if (cdb_in_valid && cdb_in_tag == dispatch_a_data[3:0]) begin
          m_av[fs] <= 1'b1; m_a[fs] <= cdb_in_data;
        end else begin
          m_av[fs] <= 1'b0;
        end
        if (dispatch_b_valid) begin
          m_bv[fs] <= 1'b1; m_b[fs] <= dispatch_b_data;
        end else if (cdb_in_valid && cdb_in_tag == dispatch_b_data[3:0]) begin
          m_bv[fs] <= 1'b1; m_b[fs] <= cdb_in_data;
        end else begin
          m_bv[fs] <= 1'b0;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin : compare
    int off;
    int occ;
    bit anyfree;
    off = model_offer();
    occ = 0;
    anyfree = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (m_busy[i]) occ++;
      else anyfree = 1'b1;
    end
    chk("cmp_request", 32'(cdb_out_request), 32'(off >= 0));
    chk("cmp_tag",  32'(cdb_out_tag),  (off >= 0) ? 32'(m_dest[off]) : 32'h0);
    chk("cmp_data", 32'(cdb_out_data),
        (off >= 0) ? 32'(model_alu(m_op[off], m_a[off], m_b[off])) : 32'h0);
    chk("cmp_ready", 32'(dispatch_ready), 32'(anyfree));
    chk("cmp_occupancy", 32'(occupancy), 32'(occ));
  end

  // ---------------- stimulus ----------------
  task automatic apply(input bit en, input bit [1:0] op, input bit [3:0] dest,
                       input bit [7:0] a, input bit av, input bit [7:0] b, input bit bv,
                       input bit cv, input bit [3:0] ct, input bit [7:0] cd, input bit acc);
    dispatch_en       = en;
    dispatch_op       = op;
    dispatch_dest_tag = dest;
    dispatch_a_data   = a;
    dispatch_a_valid  = av;
    dispatch_b_data   = b;
    dispatch_b_valid  = bv;
    cdb_in_valid      = cv;
    cdb_in_tag        = ct;
    cdb_in_data       = cd;
    cdb_out_accepted  = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit acc);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic lit(input string name, input bit req, input bit [3:0] t,
                     input bit [7:0] d, input bit [2:0] occ);
    chk({name, "_req"}, 32'(cdb_out_request), 32'(req));
    chk({name, "_tag"}, 32'(cdb_out_tag), 32'(t));
    chk({name, "_data"}, 32'(cdb_out_data), 32'(d));
    chk({name, "_occ"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_dispatch_ready", 32'(dispatch_ready), 32'h1);
    lit("reset", 0, 0, 8'h00, 0);
    rst_n = 1'b1;

    // add 3+4 -> tag 5
    apply(1, 2'd0, 4'd5, 8'd3, 1, 8'd4, 1, 0, 0, 0, 0);
    lit("add", 1, 4'd5, 8'd7, 1);
    idle(1);
    lit("add_accepted", 0, 0, 8'h00, 0);

    // sub with A waiting on tag 2; a wrong tag must not wake it
    apply(1, 2'd1, 4'd6, 8'd2, 0, 8'd9, 1, 0, 0, 0, 0);
    idle(0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 8'd99, 0);
    lit("sub_wrong_tag", 0, 0, 8'h00, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 8'd20, 0);
    lit("sub_woken", 1, 4'd6, 8'd11, 1);
    idle(1);
    lit("sub_accepted", 0, 0, 8'h00, 0);

    // subtraction wrap: 3-5
    apply(1, 2'd1, 4'd9, 8'd3, 1, 8'd5, 1, 0, 0, 0, 0);
    lit("sub_wrap", 1, 4'd9, 8'hFE, 1);
    idle(1);

    // fill all four entries, all waiting on operand A
    apply(1, 2'd0, 4'd1, 8'd8,  0, 8'h01, 1, 0, 0, 0, 0);
    apply(1, 2'd1, 4'd2, 8'd9,  0, 8'h01, 1, 0, 0, 0, 0);
    apply(1, 2'd3, 4'd3, 8'd10, 0, 8'h0F, 1, 0, 0, 0, 0);
    apply(1, 2'd2, 4'd4, 8'd11, 0, 8'hFF, 1, 0, 0, 0, 0);
    chk("full_dispatch_ready", 32'(dispatch_ready), 32'h0);
    apply(1, 2'd0, 4'd15, 8'd1, 1, 8'd1, 1, 0, 0, 0, 0);
    lit("full_ignored", 0, 0, 8'h00, 4);

    // entry 2 offered, then entry 0 readies: lock holds entry 2
    apply(0, 0, 0, 0, 0, 0, 0, 1, 4'd10, 8'hF0, 0);
    lit("lock_first", 1, 4'd3, 8'hFF, 4);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 4'd8, 8'h10, 0);
    lit("lock_held", 1, 4'd3, 8'hFF, 4);
    idle(1);
    lit("lock_next", 1, 4'd1, 8'h11, 3);
    idle(1);
    lit("lock_drained", 0, 0, 8'h00, 2);

    // dispatch bypass: A's producer broadcasts in the dispatch cycle
    apply(1, 2'd0, 4'd12, 8'd7, 0, 8'h01, 1, 1, 4'd7, 8'h55, 0);
    lit("bypass", 1, 4'd12, 8'h56, 3);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    lit("async_reset", 0, 0, 8'h00, 0);
    chk("async_reset_ready", 32'(dispatch_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // dispatch and accept in the same cycle keep occupancy
    apply(1, 2'd0, 4'd2, 8'd1, 1, 8'd1, 1, 0, 0, 0, 0);
    lit("simul_first", 1, 4'd2, 8'd2, 1);
    apply(1, 2'd2, 4'd3, 8'h3C, 1, 8'h0F, 1, 0, 0, 0, 1);
    lit("simul_both", 1, 4'd3, 8'h0C, 1);
    idle(1);
    lit("simul_done", 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
